// File: rtl/bus_turnaround_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_turnaround_arbiter
//  Description : Break-before-make arbiter for one shared tri-state data bus
//                used by two requesters (A and B). It drives the active-low
//                output enables of the dual 4-bit buffer pair. Features:
//                programmable dead time, round-robin fairness and a bounded
//                hold time with preemption.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEAD_CYC : cycles with both enables high between a release and the
//               next grant (1..2^CW-1)
//    MAX_HOLD : maximum ownership cycles while the other side requests;
//               0 disables preemption
//    CW       : width of the dead-time and hold counters
//  Ports
//    SIM_CLK  in   system clock, rising edge
//    SIM_RST  in   synchronous active-high reset
//    REQa     in   requester A wants the bus (level)
//    REQb     in   requester B wants the bus (level)
//    GNTa     out  A owns the bus (registered)
//    GNTb     out  B owns the bus (registered)
//    OEa_     out  active-low enable, buffer half a (low exactly when GNTa)
//    OEb_     out  active-low enable, buffer half b (low exactly when GNTb)
//    TOUTa    out  one-cycle pulse: A preempted by hold timeout
//    TOUTb    out  one-cycle pulse: B preempted by hold timeout
//    BUSY     out  high whenever the arbiter is not idle
// ============================================================================
module bus_turnaround_arbiter #(
  parameter int DEAD_CYC = 2,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic SIM_CLK,
  input  logic SIM_RST,
  input  logic REQa,
  input  logic REQb,
  output logic GNTa,
  output logic GNTb,
  output logic OEa_,
  output logic OEb_,
  output logic TOUTa,
  output logic TOUTb,
  output logic BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  localparam logic [CW-1:0] c_dead_last  = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] c_hold_last  = CW'(MAX_HOLD - 1);
  localparam bit            c_preempt_en = (MAX_HOLD != 0);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ptr_b;       // 1: B wins the next tie, 0: A wins
  logic          w_ptr_b_nxt;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] w_hold_nxt;
  logic [CW-1:0] r_dead;
  logic [CW-1:0] w_dead_nxt;
  logic          w_touta_nxt;
  logic          w_toutb_nxt;
  logic          w_arb;         // evaluate requests this cycle
  logic          w_pick_a;
  logic          w_pick_b;

  // Round-robin choice; only consulted when w_arb is set.
  assign w_pick_a = REQa & (~REQb | ~r_ptr_b);
  assign w_pick_b = REQb & (~REQa |  r_ptr_b);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_b_nxt = r_ptr_b;
    w_hold_nxt  = '0;
    w_dead_nxt  = '0;
    w_touta_nxt = 1'b0;
    w_toutb_nxt = 1'b0;
    w_arb       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_arb = 1'b1;
      end

      S_OWN_A: begin
        w_hold_nxt = (r_hold == '1) ? r_hold : r_hold + 1'b1;
        if (!REQa) begin
          w_state_nxt = S_TURN;
        end else if (c_preempt_en && (r_hold == c_hold_last) && REQb) begin
          w_state_nxt = S_TURN;
          w_touta_nxt = 1'b1;
        end
      end

      S_OWN_B: begin
        w_hold_nxt = (r_hold == '1) ? r_hold : r_hold + 1'b1;
        if (!REQb) begin
          w_state_nxt = S_TURN;
        end else if (c_preempt_en && (r_hold == c_hold_last) && REQa) begin
          w_state_nxt = S_TURN;
          w_toutb_nxt = 1'b1;
        end
      end

      S_TURN: begin
        // The last dead cycle arbitrates exactly like IDLE, so a pending
        // request is granted without passing through IDLE.
        if (r_dead == c_dead_last) begin
          w_arb = 1'b1;
        end else begin
          w_dead_nxt = r_dead + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_arb) begin
      if (w_pick_a) begin
        w_state_nxt = S_OWN_A;
        w_ptr_b_nxt = 1'b1;
      end else if (w_pick_b) begin
        w_state_nxt = S_OWN_B;
        w_ptr_b_nxt = 1'b0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register; outputs are registered decodes of the next state so that
  // they change on the same edge as the state and never depend on REQ
  // combinationally.
  // --------------------------------------------------------------------------
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_state <= S_IDLE;
      r_ptr_b <= 1'b0;
      r_hold  <= '0;
      r_dead  <= '0;
      GNTa    <= 1'b0;
      GNTb    <= 1'b0;
      OEa_    <= 1'b1;
      OEb_    <= 1'b1;
      TOUTa   <= 1'b0;
      TOUTb   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr_b <= w_ptr_b_nxt;
      r_hold  <= w_hold_nxt;
      r_dead  <= w_dead_nxt;
      GNTa    <= (w_state_nxt == S_OWN_A);
      GNTb    <= (w_state_nxt == S_OWN_B);
      OEa_    <= (w_state_nxt != S_OWN_A);
      OEb_    <= (w_state_nxt != S_OWN_B);
      TOUTa   <= w_touta_nxt;
      TOUTb   <= w_toutb_nxt;
      BUSY    <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_turnaround_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_turnaround_arbiter
//  Description : Self-checking bench for bus_turnaround_arbiter. Four
//                instances share the request inputs:
//                  0: DEAD_CYC=2 MAX_HOLD=4  (directed vector table)
//                  1: DEAD_CYC=2 MAX_HOLD=0  (no-preemption sequence)
//                  2: DEAD_CYC=1 MAX_HOLD=3  (random traffic)
//                  3: DEAD_CYC=3 MAX_HOLD=6  (random traffic)
//                Invariants and dead gaps are checked on all instances
//                every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_turnaround_arbiter;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic reqa = 1'b0;
  logic reqb = 1'b0;

  logic gnta [4];
  logic gntb [4];
  logic oea_n[4];
  logic oeb_n[4];
  logic touta[4];
  logic toutb[4];
  logic busy [4];

  always #5 clk = ~clk;

  bus_turnaround_arbiter #(.DEAD_CYC(2), .MAX_HOLD(4), .CW(5)) u_dut (
    .SIM_CLK(clk), .SIM_RST(rst), .REQa(reqa), .REQb(reqb),
    .GNTa(gnta[0]), .GNTb(gntb[0]), .OEa_(oea_n[0]), .OEb_(oeb_n[0]),
    .TOUTa(touta[0]), .TOUTb(toutb[0]), .BUSY(busy[0]));

  bus_turnaround_arbiter #(.DEAD_CYC(2), .MAX_HOLD(0), .CW(5)) u_nohold (
    .SIM_CLK(clk), .SIM_RST(rst), .REQa(reqa), .REQb(reqb),
    .GNTa(gnta[1]), .GNTb(gntb[1]), .OEa_(oea_n[1]), .OEb_(oeb_n[1]),
    .TOUTa(touta[1]), .TOUTb(toutb[1]), .BUSY(busy[1]));

  bus_turnaround_arbiter #(.DEAD_CYC(1), .MAX_HOLD(3), .CW(5)) u_d1 (
    .SIM_CLK(clk), .SIM_RST(rst), .REQa(reqa), .REQb(reqb),
    .GNTa(gnta[2]), .GNTb(gntb[2]), .OEa_(oea_n[2]), .OEb_(oeb_n[2]),
    .TOUTa(touta[2]), .TOUTb(toutb[2]), .BUSY(busy[2]));

  bus_turnaround_arbiter #(.DEAD_CYC(3), .MAX_HOLD(6), .CW(5)) u_d3 (
    .SIM_CLK(clk), .SIM_RST(rst), .REQa(reqa), .REQb(reqb),
    .GNTa(gnta[3]), .GNTb(gntb[3]), .OEa_(oea_n[3]), .OEb_(oeb_n[3]),
    .TOUTa(touta[3]), .TOUTb(toutb[3]), .BUSY(busy[3]));

  // Output word: {GNTa, GNTb, OEa_, OEb_, TOUTa, TOUTb, BUSY}
  localparam logic [6:0] E_I  = 7'b0011000;  // idle / reset
  localparam logic [6:0] E_A  = 7'b1001001;  // A owns
  localparam logic [6:0] E_B  = 7'b0110001;  // B owns
  localparam logic [6:0] E_T  = 7'b0011001;  // dead time
  localparam logic [6:0] E_TA = 7'b0011101;  // first dead cycle, A timed out
  localparam logic [6:0] E_TB = 7'b0011011;  // first dead cycle, B timed out

  typedef struct {
    logic       rst;
    logic       a;
    logic       b;
    logic [6:0] exp;
    string      nm;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] sb_exp[$];
  string      sb_nm[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int   dead_of[4] = '{2, 2, 1, 3};
  logic prev_oa[4];
  logic prev_ob[4];
  logic prev_ta[4];
  logic prev_tb[4];
  bit   pend[4];
  int   rise_cyc[4];
  int   n_gap[4];

  function automatic logic [6:0] outs(input int i);
    return {gnta[i], gntb[i], oea_n[i], oeb_n[i], touta[i], toutb[i], busy[i]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle invariants and dead-gap measurement on every instance.
  task automatic monitor();
    for (int i = 0; i < 4; i++) begin
      logic [6:0] o;
      logic ga, gb, oa, ob, ta, tb, bz, rose, fell;
      o  = outs(i);
      ga = o[6]; gb = o[5]; oa = o[4]; ob = o[3];
      ta = o[2]; tb = o[1]; bz = o[0];
      check($sformatf("gnt_mutex[%0d]", i), {31'd0, ga & gb}, 32'd0);
      check($sformatf("oea_vs_gnta[%0d]", i), {31'd0, oa}, {31'd0, ~ga});
      check($sformatf("oeb_vs_gntb[%0d]", i), {31'd0, ob}, {31'd0, ~gb});
      check($sformatf("tout_excl[%0d]", i), {31'd0, ta & tb}, 32'd0);
      check($sformatf("busy_cover[%0d]", i), {31'd0, (ga | gb | ta | tb) & ~bz}, 32'd0);
      check($sformatf("tout_pulse[%0d]", i),
            {31'd0, (ta & prev_ta[i]) | (tb & prev_tb[i])}, 32'd0);
      rose = (~prev_oa[i] & oa) | (~prev_ob[i] & ob);
      fell = (prev_oa[i] & ~oa) | (prev_ob[i] & ~ob);
      if (fell && pend[i]) begin
        check($sformatf("dead_gap[%0d]", i), cyc - rise_cyc[i], dead_of[i]);
        n_gap[i]++;
        pend[i] = 1'b0;
      end
      if (rose) begin
        pend[i]     = 1'b1;
        rise_cyc[i] = cyc;
      end
      if (!bz) pend[i] = 1'b0;
      prev_oa[i] = oa;
      prev_ob[i] = ob;
      prev_ta[i] = ta;
      prev_tb[i] = tb;
    end
  endtask

  task automatic step(input logic r, input logic a, input logic b);
    @(negedge clk);
    rst  = r;
    reqa = a;
    reqb = b;
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic add(input int n, input logic r, input logic a, input logic b,
                     input logic [6:0] e, input string nm);
    for (int k = 0; k < n; k++) begin
      vec_t v;
      v.rst = r; v.a = a; v.b = b; v.exp = e; v.nm = nm;
      vecs.push_back(v);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      prev_oa[i]  = 1'b1;
      prev_ob[i]  = 1'b1;
      prev_ta[i]  = 1'b0;
      prev_tb[i]  = 1'b0;
      pend[i]     = 1'b0;
      rise_cyc[i] = 0;
      n_gap[i]    = 0;
    end

    // ---------------- directed table for instance 0 ----------------
    add(2, 1, 0, 0, E_I,  "reset");
    // single A
    add(4, 0, 1, 0, E_A,  "t1_own_a");
    add(2, 0, 0, 0, E_T,  "t1_turn");
    add(2, 0, 0, 0, E_I,  "t1_idle");
    // simultaneous after reset: A first, B after two dead cycles
    add(1, 1, 0, 0, E_I,  "reset2");
    add(3, 0, 1, 1, E_A,  "t2_own_a");
    add(2, 0, 0, 1, E_T,  "t2_turn");
    add(2, 0, 0, 1, E_B,  "t2_own_b");
    add(2, 0, 0, 0, E_T,  "t2_turn_b");
    add(1, 0, 0, 0, E_I,  "t2_idle");
    // A times out, B granted, A re-granted only after B releases
    add(1, 0, 1, 0, E_A,  "t3_own_a");
    add(3, 0, 1, 1, E_A,  "t3_hold_a");
    add(1, 0, 1, 1, E_TA, "t3_tout_a");
    add(1, 0, 1, 1, E_T,  "t3_turn");
    add(2, 0, 1, 1, E_B,  "t3_own_b");
    add(2, 0, 1, 0, E_T,  "t3_turn_b");
    add(1, 0, 1, 0, E_A,  "t3_regrant_a");
    add(2, 0, 0, 0, E_T,  "t3_turn_a");
    add(1, 0, 0, 0, E_I,  "t3_idle");
    // B times out, A wins next
    add(1, 0, 0, 1, E_B,  "t4_own_b");
    add(3, 0, 1, 1, E_B,  "t4_hold_b");
    add(1, 0, 1, 1, E_TB, "t4_tout_b");
    add(1, 0, 1, 1, E_T,  "t4_turn");
    add(1, 0, 1, 1, E_A,  "t4_own_a");
    add(2, 0, 0, 0, E_T,  "t4_turn_a");
    add(1, 0, 0, 0, E_I,  "t4_idle");
    // REQb dropping during dead time is not granted
    add(1, 0, 1, 0, E_A,  "g_own_a");
    add(1, 0, 0, 1, E_T,  "g_turn0");
    add(1, 0, 0, 0, E_T,  "g_turn1");
    add(2, 0, 0, 0, E_I,  "g_idle");
    // release on the timeout cycle is a plain release (ptr=B here)
    add(1, 0, 0, 1, E_B,  "r_own_b");
    add(3, 0, 1, 1, E_B,  "r_hold_b");
    add(1, 0, 1, 0, E_T,  "r_release_not_tout");
    add(1, 0, 1, 0, E_T,  "r_turn");
    add(1, 0, 1, 0, E_A,  "r_own_a");
    add(2, 0, 0, 0, E_T,  "r_turn_a");
    add(1, 0, 0, 0, E_I,  "r_idle");
    // reset during OWN_B
    add(2, 0, 0, 1, E_B,  "rb_own_b");
    add(1, 1, 1, 1, E_I,  "rb_reset");
    add(1, 0, 0, 0, E_I,  "rb_idle");
    add(1, 0, 1, 1, E_A,  "rb_ptr_a");
    add(2, 0, 0, 0, E_T,  "rb_turn");
    add(1, 0, 0, 0, E_I,  "rb_idle2");
    // reset during OWN_A with pointer at B: pointer must return to A
    add(2, 0, 1, 0, E_A,  "ra_own_a");
    add(1, 1, 1, 1, E_I,  "ra_reset");
    add(1, 0, 1, 1, E_A,  "ra_ptr_reset");
    add(2, 0, 0, 0, E_T,  "ra_turn");
    add(1, 0, 0, 0, E_I,  "ra_idle");
    // reset during TURN
    add(1, 0, 1, 0, E_A,  "rt_own_a");
    add(1, 0, 0, 0, E_T,  "rt_turn");
    add(1, 1, 0, 1, E_I,  "rt_reset");
    add(1, 0, 0, 1, E_B,  "rt_own_b");
    add(2, 0, 0, 0, E_T,  "rt_turn_b");
    add(1, 0, 0, 0, E_I,  "rt_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      logic [6:0] e;
      string      nm;
      sb_exp.push_back(vecs[i].exp);
      sb_nm.push_back(vecs[i].nm);
      step(vecs[i].rst, vecs[i].a, vecs[i].b);
      e  = sb_exp.pop_front();
      nm = sb_nm.pop_front();
      check(nm, {25'd0, outs(0)}, {25'd0, e});
    end

    // ---------------- MAX_HOLD=0: no preemption (instance 1) ----------------
    step(1, 0, 0);
    step(0, 1, 0);
    check("nohold_grant", {25'd0, outs(1)}, {25'd0, E_A});
    for (int k = 0; k < 100; k++) begin
      step(0, 1, 1);
      check("nohold_keep", {25'd0, outs(1)}, {25'd0, E_A});
    end
    step(0, 0, 1);
    check("nohold_turn0", {25'd0, outs(1)}, {25'd0, E_T});
    step(0, 0, 1);
    check("nohold_turn1", {25'd0, outs(1)}, {25'd0, E_T});
    step(0, 0, 1);
    check("nohold_own_b", {25'd0, outs(1)}, {25'd0, E_B});

    // ---------------- random traffic ----------------
    step(1, 0, 0);
    begin
      logic a, b;
      a = 1'b0;
      b = 1'b0;
      for (int k = 0; k < 10000; k++) begin
        if ($urandom_range(5) == 0) a = ~a;
        if ($urandom_range(5) == 0) b = ~b;
        step(0, a, b);
      end
    end
    check("gaps_seen_d1", {31'd0, n_gap[2] > 0}, 32'd1);
    check("gaps_seen_d3", {31'd0, n_gap[3] > 0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_turnaround_arbiter.md
Name: bus_turnaround_arbiter

Overview:
- Arbitrates one shared tri-state data bus between two requesters, A and B.
- Drives the active-low output enables of the dual 4-bit buffer pair (one enable per half) in the fixed/erasable memory path.
- Guarantees break-before-make with a programmable dead time, round-robin fairness and a bounded hold time.
- Sits between the memory sequencing logic (requesters) and the buffer enables.

Parameters:
DEAD_CYC, 2, dead-time cycles with both enables high between any release and the next grant; legal range 1..2^CW-1
MAX_HOLD, 16, max cycles an owner keeps the bus while the other side requests; 0 disables preemption
CW, 5, width of the dead-time and hold counters; must hold max(DEAD_CYC, MAX_HOLD)

Ports:
SIM_CLK  in  1  system clock; all state updates on the rising edge
SIM_RST  in  1  synchronous reset, active-high
REQa  in  1  requester A wants the bus; level, held until done
REQb  in  1  requester B wants the bus
GNTa  out  1  A owns the bus (registered)
GNTb  out  1  B owns the bus (registered)
OEa_  out  1  active-low enable for buffer half a; low exactly when GNTa=1
OEb_  out  1  active-low enable for buffer half b; low exactly when GNTb=1
TOUTa  out  1  one-cycle pulse: A preempted by hold timeout
TOUTb  out  1  one-cycle pulse: B preempted by hold timeout
BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Clock/reset: one clock, SIM_CLK. SIM_RST is synchronous and active-high.
- Reset values: OEa_=OEb_=1, GNTa=GNTb=0, TOUTa=TOUTb=0, BUSY=0, state=IDLE, priority pointer=A, counters=0.
- Reset mid-operation: all outputs return to reset values at the sampling edge, regardless of state or counters.
- States: IDLE, OWN_A, OWN_B, TURN. All outputs are registered and decoded from state, so there are no combinational paths from REQ to outputs.
- IDLE:
  - Only REQa sampled high -> OWN_A.
  - Only REQb sampled high -> OWN_B.
  - Both high -> side named by the pointer; the pointer then flips to the other side.
  - A single-requester grant also sets the pointer to the other side.
  - Latency: REQ sampled at edge k gives GNT=1 and OE_=0 after edge k (1 cycle).
- OWN_x:
  - Hold counter clears on entry and increments each cycle, saturating.
  - Release when REQx is sampled low -> TURN.
  - Preempt when MAX_HOLD!=0, the hold counter has reached MAX_HOLD-1, and the other REQ is high -> TURN, with TOUTx=1 for the first TURN cycle only.
  - Otherwise stay in OWN_x.
  - Preemption is not possible if the other side never requests.
- TURN:
  - GNT and OE_ of the previous owner drop on the same edge that enters TURN.
  - Both OE_ stay high for exactly DEAD_CYC cycles, counted by the dead-time counter.
  - On the last TURN cycle, requests are evaluated exactly as in IDLE: go directly to OWN_x, or to IDLE if none are pending.
  - The gap between one OE_ rising and the other OE_ falling is therefore exactly DEAD_CYC cycles.
- Preempted owner with REQ still high: the pointer already favours the other side, so the preempted owner is re-granted only after the other side releases or is itself preempted.
- Invariants, checked every cycle:
  - Never GNTa&GNTb.
  - Never !OEa_&!OEb_.
  - OEx_ == !GNTx.
  - TOUTa&TOUTb never both high.
- Glitches: REQ pulses shorter than one cycle that are not sampled have no effect. A REQ that drops while in TURN is not granted.

Test Plan:
- Single A, DEAD_CYC=2: REQa high at edge 1, low at edge 5 -> GNTa/OEa_ active edges 1..5 (4 cycles), TURN 2 cycles, IDLE after edge 7, BUSY high edges 1..7.
- Simultaneous after reset: REQa=REQb=1 at edge 1 -> A granted first; REQa drops at edge 4 -> OEa_ high at edge 4, OEb_ low at edge 6 (exactly 2 dead cycles), GNTb=1.
- Timeout, MAX_HOLD=4: A owns, REQb raised while REQa stays high -> after 4 cycles of A ownership, TOUTa=1 for 1 cycle, B granted DEAD_CYC later; A re-granted only after REQb drops.
- MAX_HOLD=0: A holds 100 cycles with REQb high -> no TOUT; B granted DEAD_CYC cycles after REQa falls.
- Reset mid-ownership: SIM_RST=1 during OWN_B -> next edge OEb_=1, GNTb=0, BUSY=0; after release, REQa=REQb=1 -> A granted (pointer reset to A).
- Randomized REQ toggling for 10k cycles, DEAD_CYC in {1,3}: assertions never fire; each observed dead gap equals DEAD_CYC.
